// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: bus widths, load encodings
// and the packed layouts of the execute, writeback and forwarding buses.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 156;
    localparam int MS_TO_WS_BUS_WD = 151;
    localparam int MS_TO_DS_BUS_WD = 39;

    // bit2 = unsigned, [1:0] = size (00 word, 01 byte, 10 half)
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b101;
    localparam logic [2:0] LD_HU = 3'b110;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10
    } ld_size_e;

    typedef struct packed {
        logic        ertn;
        logic        sys_exce;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic [31:0] csr_wmask;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_ws_t;

    typedef struct packed {
        logic       wait_data;
        logic       res_from_mem;
        logic [2:0] load_op;
        ms_ws_t     body;
    } es_ms_t;

    typedef struct packed {
        logic        blocking;
        logic        fwd_we;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_ds_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and sign/zero extension (purely combinational).
// Ports: load_op, addr[1:0], rdata in; ext (32-bit extended value) out.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        uns;

    assign uns = load_op[2];

    always_comb begin
        byte_v = rdata[7:0];
        unique case (addr)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
        endcase
    end

    assign half_v = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ext = rdata;
        unique case (ld_size_e'(load_op[1:0]))
            SZ_BYTE: ext = {{24{~uns & byte_v[7]}}, byte_v};
            SZ_HALF: ext = {{16{~uns & half_v[15]}}, half_v};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds EX results, waits for load data,
// aligns it and forwards a bundle to WB plus hazard info to ID.
// Ports: clk/resetn, EX handshake+bus in, WB handshake+bus out,
// ms_to_ds_bus forwarding, ms_flush_hint, ws_flush, data SRAM response.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    output logic                       ms_flush_hint,
    input  logic                       ws_flush,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    logic        ms_valid_q, ms_valid_d;
    es_ms_t      bus_q, bus_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    logic        live_ok;
    logic        ms_ready_go;
    logic        leaving;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] ld_data;
    logic [31:0] ld_ext;
    logic [31:0] final_result;
    ms_ws_t      ws_out;
    ms_ds_t      ds_out;

    // A response only belongs to the resident instruction once all
    // responses owed to flushed instructions have been swallowed.
    assign live_ok = data_sram_data_ok && (discard_cnt_q == 2'd0);

    assign ms_ready_go = !bus_q.wait_data || buf_valid_q || live_ok;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ws_flush;
    assign leaving = ms_valid_q && ms_ready_go && ws_allowin;

    assign cnt_inc = ws_flush && ms_valid_q && bus_q.wait_data
                     && !buf_valid_q && !live_ok;
    assign cnt_dec = data_sram_data_ok && (discard_cnt_q != 2'd0);

    assign ld_data = buf_valid_q ? buf_data_q : data_sram_rdata;

    mem_load_align u_align (
        .load_op (bus_q.load_op),
        .addr    (bus_q.body.result[1:0]),
        .rdata   (ld_data),
        .ext     (ld_ext)
    );

    assign final_result = bus_q.res_from_mem ? ld_ext
                                             : bus_q.body.result;

    always_comb begin
        ws_out        = bus_q.body;
        ws_out.result = final_result;
    end
    assign ms_to_ws_bus = ws_out;

    always_comb begin
        ds_out.blocking = ms_valid_q
            && ((bus_q.res_from_mem && !ms_ready_go)
                || bus_q.body.csr_we
                || bus_q.body.sys_exce
                || bus_q.body.ertn);
        ds_out.fwd_we = ms_valid_q && bus_q.body.gr_we;
        ds_out.dest   = bus_q.body.dest;
        ds_out.result = final_result;
    end
    assign ms_to_ds_bus = ds_out;

    assign ms_flush_hint = ms_valid_q
        && (bus_q.body.sys_exce || bus_q.body.ertn);

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ws_flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        bus_d = bus_q;
        if (es_to_ms_valid && ms_allowin) begin
            bus_d = es_to_ms_bus;
        end

        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (ws_flush || leaving) begin
            buf_valid_d = 1'b0;
            buf_data_d  = 32'h0;
        end else if (ms_valid_q && bus_q.wait_data && !buf_valid_q
                     && live_ok && !ws_allowin) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end

        discard_cnt_d = discard_cnt_q;
        if (cnt_inc && !cnt_dec) begin
            discard_cnt_d = discard_cnt_q + 2'd1;
        end else if (cnt_dec && !cnt_inc) begin
            discard_cnt_d = discard_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            bus_q         <= '0;
            buf_valid_q   <= 1'b0;
            buf_data_q    <= 32'h0;
            discard_cnt_q <= 2'd0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            bus_q         <= bus_d;
            buf_valid_q   <= buf_valid_d;
            buf_data_q    <= buf_data_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // At most one load can be outstanding per flushed slot, so the
    // count should never climb to its ceiling.
    a_no_sat: assert property (
        @(posedge clk) disable iff (!resetn) discard_cnt_q != 2'd3
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Drives EX/WB/SRAM inputs after each edge; checks combinational outputs.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ws_allowin = 1'b1;
    logic         ms_allowin;
    logic         es_to_ms_valid = 1'b0;
    logic [155:0] es_to_ms_bus = '0;
    logic         ms_to_ws_valid;
    logic [150:0] ms_to_ws_bus;
    logic [38:0]  ms_to_ds_bus;
    logic         ms_flush_hint;
    logic         ws_flush = 1'b0;
    logic         data_ok = 1'b0;
    logic [31:0]  rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] PC = 32'h1c00_0000;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .ms_flush_hint     (ms_flush_hint),
        .ws_flush          (ws_flush),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [155:0] mk(
        input logic w, input logic rfm, input logic [2:0] op,
        input logic gwe, input logic [4:0] dst, input logic [31:0] alu,
        input logic csr_we, input logic sys, input logic ertn);
        return {w, rfm, op, ertn, sys, 14'h0, csr_we, 32'h0, 32'h0,
                gwe, dst, alu, PC};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [155:0] b);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        cyc();
        es_to_ms_valid = 1'b0;
    endtask

    logic [2:0]  t_op  [4];
    logic [31:0] t_alu [4];
    logic [31:0] t_rd  [4];
    logic [31:0] t_exp [4];

    initial begin
        t_op[0] = 3'b010; t_alu[0] = 32'h4000_0002;
        t_rd[0] = 32'h8001_0000; t_exp[0] = 32'hFFFF_8001;
        t_op[1] = 3'b101; t_alu[1] = 32'h4000_0001;
        t_rd[1] = 32'h0000_F000; t_exp[1] = 32'h0000_00F0;
        t_op[2] = 3'b001; t_alu[2] = 32'h4000_0000;
        t_rd[2] = 32'h0000_007F; t_exp[2] = 32'h0000_007F;
        t_op[3] = 3'b000; t_alu[3] = 32'h4000_0000;
        t_rd[3] = 32'hCAFE_BABE; t_exp[3] = 32'hCAFE_BABE;

        #12;
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_ws_valid", ms_to_ws_valid, 0);
        chk("rst_ds_bus", ms_to_ds_bus, 0);
        chk("rst_hint", ms_flush_hint, 0);
        resetn = 1'b1;
        cyc();

        // non-load ALU op
        latch(mk(0, 0, 3'b000, 1, 5'd5, 32'h1234, 0, 0, 0));
        chk("alu_valid", ms_to_ws_valid, 1);
        chk("alu_result", ms_to_ws_bus[63:32], 32'h1234);
        chk("alu_pc", ms_to_ws_bus[31:0], PC);
        chk("alu_ds", ms_to_ds_bus, {1'b0, 1'b1, 5'd5, 32'h1234});
        cyc();
        chk("alu_gone", ms_to_ws_valid, 0);

        // signed byte load, response after 3 cycles
        latch(mk(1, 1, 3'b001, 1, 5'd7, 32'h1000_0003, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            chk("ldb_block", ms_to_ds_bus[38], 1);
            chk("ldb_wait", ms_to_ws_valid, 0);
            cyc();
        end
        data_ok = 1'b1;
        rdata   = 32'h80FF_FFFF;
        #1;
        chk("ldb_valid", ms_to_ws_valid, 1);
        chk("ldb_result", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
        chk("ldb_unblock", ms_to_ds_bus[38], 0);
        cyc();
        data_ok = 1'b0;
        #1;
        chk("ldb_gone", ms_to_ws_valid, 0);

        // unsigned half load buffered while WB stalls
        latch(mk(1, 1, 3'b110, 1, 5'd8, 32'h2000_0002, 0, 0, 0));
        data_ok    = 1'b1;
        rdata      = 32'hABCD_0000;
        ws_allowin = 1'b0;
        #1;
        chk("ldhu_valid", ms_to_ws_valid, 1);
        chk("ldhu_stall", ms_allowin, 0);
        cyc();
        data_ok = 1'b0;
        rdata   = 32'hDEAD_BEEF;
        #1;
        chk("ldhu_buf_valid", ms_to_ws_valid, 1);
        chk("ldhu_buf_res", ms_to_ws_bus[63:32], 32'h0000_ABCD);
        ws_allowin = 1'b1;
        #1;
        chk("ldhu_release", ms_allowin, 1);
        cyc();
        chk("ldhu_gone", ms_to_ws_valid, 0);

        // flush while waiting; stale response discarded
        latch(mk(1, 1, 3'b000, 1, 5'd9, 32'h3000_0000, 0, 0, 0));
        ws_flush = 1'b1;
        #1;
        chk("fl_drop", ms_to_ws_valid, 0);
        cyc();
        ws_flush = 1'b0;
        #1;
        chk("fl_empty", ms_allowin, 1);
        chk("fl_fwd", ms_to_ds_bus[37], 0);
        chk("fl_cnt", dut.discard_cnt_q, 1);
        latch(mk(1, 1, 3'b000, 1, 5'd10, 32'h3000_0004, 0, 0, 0));
        data_ok = 1'b1;
        rdata   = 32'h1111_1111;
        #1;
        chk("fl_stale", ms_to_ws_valid, 0);
        cyc();
        data_ok = 1'b0;
        #1;
        chk("fl_cnt0", dut.discard_cnt_q, 0);
        chk("fl_wait", ms_to_ws_valid, 0);
        data_ok = 1'b1;
        rdata   = 32'h2222_2222;
        #1;
        chk("fl_new_valid", ms_to_ws_valid, 1);
        chk("fl_new_res", ms_to_ws_bus[63:32], 32'h2222_2222);
        cyc();
        data_ok = 1'b0;

        // flush and live response in the same cycle
        latch(mk(1, 1, 3'b000, 1, 5'd11, 32'h3000_0008, 0, 0, 0));
        ws_flush = 1'b1;
        data_ok  = 1'b1;
        rdata    = 32'h3333_3333;
        #1;
        chk("flok_drop", ms_to_ws_valid, 0);
        cyc();
        ws_flush = 1'b0;
        data_ok  = 1'b0;
        #1;
        chk("flok_cnt", dut.discard_cnt_q, 0);
        chk("flok_empty", ms_allowin, 1);

        // flush hint from a resident syscall
        latch(mk(0, 0, 3'b000, 0, 5'd0, 32'h0, 0, 1, 0));
        ws_allowin = 1'b0;
        #1;
        chk("hint_on", ms_flush_hint, 1);
        chk("hint_block", ms_to_ds_bus[38], 1);
        cyc();
        ws_flush = 1'b1;
        #1;
        chk("hint_flush_valid", ms_to_ws_valid, 0);
        cyc();
        ws_flush   = 1'b0;
        ws_allowin = 1'b1;
        #1;
        chk("hint_empty", ms_allowin, 1);
        chk("hint_off", ms_flush_hint, 0);

        // alignment table, response one cycle after entry
        for (int i = 0; i < 4; i++) begin
            latch(mk(1, 1, t_op[i], 1, 5'd12, t_alu[i], 0, 0, 0));
            data_ok = 1'b1;
            rdata   = t_rd[i];
            #1;
            chk("align_res", ms_to_ws_bus[63:32], t_exp[i]);
            chk("align_fwd", ms_to_ds_bus[31:0], t_exp[i]);
            cyc();
            data_ok = 1'b0;
        end

        // reset in the middle of a load with a pending discard
        latch(mk(1, 1, 3'b000, 1, 5'd13, 32'h5000_0000, 0, 0, 0));
        ws_flush = 1'b1;
        cyc();
        ws_flush = 1'b0;
        latch(mk(1, 1, 3'b010, 1, 5'd14, 32'h5000_0002, 0, 0, 0));
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_allowin", ms_allowin, 1);
        chk("mrst_valid", ms_to_ws_valid, 0);
        chk("mrst_ds", ms_to_ds_bus, 0);
        chk("mrst_hint", ms_flush_hint, 0);
        chk("mrst_cnt", dut.discard_cnt_q, 0);
        #10;
        resetn = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
